// File: rtl/cache_pkg.sv
// Shared cache geometry plus the types used by the per-set LRU matrix store.
// A 4-way cache keeps six upper-triangle ordering bits per set.
package cache_pkg;

   localparam int BLOCK_AMOUNT = 4;
   localparam int SET_AMOUNT   = 4;
   localparam int SET_BITS     = $clog2(SET_AMOUNT);
   localparam int MATRIX_WIDTH = BLOCK_AMOUNT * (BLOCK_AMOUNT - 1) / 2;

   typedef enum logic {LM_INIT, LM_IDLE} lru_mem_state_t;

   typedef logic [MATRIX_WIDTH-1:0] lru_vec_t;

   // All ones ranks block 0 as MRU and the last block as the next victim.
   localparam lru_vec_t LRU_INIT_VEC = '1;

endpackage

// File: rtl/lru_matrix_mem_if.sv
// Matrix read/write port between the LRU controller (master) and the matrix store (slave).
interface lru_matrix_mem_if import cache_pkg::*; #(
   parameter int CNT_W = 8
) ();

   logic [SET_BITS-1:0] addr_i;
   logic                we_i;
   lru_vec_t            wdata_i;
   lru_vec_t            rdata_o;
   logic                clear_i;
   logic                ready_o;
   logic [CNT_W-1:0]    drop_cnt_o;

   modport master (
      output addr_i, we_i, wdata_i, clear_i,
      input  rdata_o, ready_o, drop_cnt_o
   );

   modport slave (
      input  addr_i, we_i, wdata_i, clear_i,
      output rdata_o, ready_o, drop_cnt_o
   );

endinterface

// File: rtl/lru_matrix_mem.sv
// Per-set LRU ordering matrix store: asynchronous reads, registered writes, and an
// init sweep after reset or on clear that parks every set at LRU_INIT_VEC.
module lru_matrix_mem import cache_pkg::*; #(
   parameter int CNT_W = 8
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   lru_matrix_mem_if.slave bus
);

   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SET_AMOUNT - 1);

   lru_vec_t            mem [SET_AMOUNT];

   lru_mem_state_t      state_q, state_d;
   logic [SET_BITS-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]    drop_q, drop_d;

   logic                mem_we;
   logic [SET_BITS-1:0] mem_addr;
   lru_vec_t            mem_data;
   logic                drop;
   logic                in_range;

   // Widened compare so a non-power-of-two set count cannot alias onto a real set.
   assign in_range = ({1'b0, bus.addr_i} < (SET_BITS + 1)'(SET_AMOUNT));

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= LM_INIT;
         ptr_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      drop_d   = drop_q;
      mem_we   = 1'b0;
      mem_addr = ptr_q;
      mem_data = LRU_INIT_VEC;
      drop     = 1'b0;

      unique case (state_q)
         LM_INIT: begin
            mem_we = 1'b1;
            drop   = bus.we_i && in_range;
            if (bus.clear_i) begin
               ptr_d = '0;
            end else if (ptr_q == LAST_SET) begin
               ptr_d   = '0;
               state_d = LM_IDLE;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         LM_IDLE: begin
            // A clear takes priority and discards any write arriving with it.
            if (bus.clear_i) begin
               state_d = LM_INIT;
               ptr_d   = '0;
               drop    = bus.we_i && in_range;
            end else if (bus.we_i && in_range) begin
               mem_we   = 1'b1;
               mem_addr = bus.addr_i;
               mem_data = bus.wdata_i;
            end
         end
      endcase

      if (drop && (drop_q != '1)) begin
         drop_d = drop_q + 1'b1;
      end
   end

   // The array has no reset of its own; the sweep fills it, and a write in a reset cycle is lost.
   always_ff @(posedge clk_i) begin
      if (rstn_i && mem_we) begin
         mem[mem_addr] <= mem_data;
      end
   end

   assign bus.rdata_o    = ((state_q == LM_IDLE) && in_range) ? mem[bus.addr_i] : LRU_INIT_VEC;
   assign bus.ready_o    = (state_q == LM_IDLE);
   assign bus.drop_cnt_o = drop_q;

endmodule

// File: tb/tb_lru_matrix_mem.sv
// Directed self-checking bench for lru_matrix_mem (4 sets, 6-bit matrices, 2-bit drop counter).
module tb_lru_matrix_mem;
   import cache_pkg::*;

   localparam int CNT_W = 2;
   localparam logic [5:0] ONES = 6'b111111;

   logic clk;
   logic rstn;

   int checkCount = 0;
   int passCount  = 0;

   lru_matrix_mem_if #(.CNT_W(CNT_W)) bus ();

   lru_matrix_mem #(.CNT_W(CNT_W)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [SET_BITS-1:0] addr,
                                input logic [MATRIX_WIDTH-1:0] wdata, input logic clear);
      bus.we_i    = we;
      bus.addr_i  = addr;
      bus.wdata_i = wdata;
      bus.clear_i = clear;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllSets(input string tag);
      for (int a = 0; a < SET_AMOUNT; a++) begin
         applyStimulus(1'b0, SET_BITS'(a), '0, 1'b0);
         checkOutput($sformatf("%s_set%0d", tag, a), 32'(bus.rdata_o), 32'(ONES));
      end
   endtask

   initial begin
      rstn = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0);

      // Reset state and first sweep
      tick();
      checkOutput("rst_ready", 32'(bus.ready_o), 32'd0);
      checkOutput("rst_drop", 32'(bus.drop_cnt_o), 32'd0);
      checkOutput("rst_rdata_forced", 32'(bus.rdata_o), 32'(ONES));
      rstn = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         checkOutput($sformatf("sweep1_ready_c%0d", i), 32'(bus.ready_o), 32'd0);
      end
      tick();
      checkOutput("sweep1_ready_up", 32'(bus.ready_o), 32'd1);
      checkAllSets("sweep1");
      checkOutput("sweep1_drop", 32'(bus.drop_cnt_o), 32'd0);

      // IDLE write, no same-cycle bypass
      applyStimulus(1'b1, 2'd2, 6'b010101, 1'b0);
      checkOutput("wr2_same_cycle", 32'(bus.rdata_o), 32'(ONES));
      tick();
      applyStimulus(1'b0, 2'd2, '0, 1'b0);
      checkOutput("wr2_next_cycle", 32'(bus.rdata_o), 32'(6'b010101));
      applyStimulus(1'b0, 2'd1, '0, 1'b0);
      checkOutput("wr2_neighbour", 32'(bus.rdata_o), 32'(ONES));

      // Write addr 3 then clear: sweep restores everything
      applyStimulus(1'b1, 2'd3, 6'b000000, 1'b0);
      tick();
      applyStimulus(1'b0, 2'd3, '0, 1'b0);
      checkOutput("wr3_visible", 32'(bus.rdata_o), 32'(6'b000000));
      applyStimulus(1'b0, 2'd3, '0, 1'b1);
      tick();
      applyStimulus(1'b0, 2'd3, '0, 1'b0);
      checkOutput("clr_ready_c0", 32'(bus.ready_o), 32'd0);
      checkOutput("clr_rdata_forced", 32'(bus.rdata_o), 32'(ONES));
      for (int i = 1; i < 4; i++) begin
         tick();
         checkOutput($sformatf("clr_ready_c%0d", i), 32'(bus.ready_o), 32'd0);
      end
      tick();
      checkOutput("clr_ready_up", 32'(bus.ready_o), 32'd1);
      applyStimulus(1'b0, 2'd3, '0, 1'b0);
      checkOutput("clr_set3", 32'(bus.rdata_o), 32'(ONES));
      applyStimulus(1'b0, 2'd2, '0, 1'b0);
      checkOutput("clr_set2", 32'(bus.rdata_o), 32'(ONES));

      // Dropped writes: with clear, then during INIT; counter saturates at 3
      applyStimulus(1'b1, 2'd1, 6'b000000, 1'b1);
      tick();
      checkOutput("drop_with_clear", 32'(bus.drop_cnt_o), 32'd1);
      applyStimulus(1'b1, 2'd0, 6'b000000, 1'b0);
      tick();
      checkOutput("drop_init_1", 32'(bus.drop_cnt_o), 32'd2);
      tick();
      checkOutput("drop_init_2", 32'(bus.drop_cnt_o), 32'd3);
      tick();
      checkOutput("drop_sat_4th", 32'(bus.drop_cnt_o), 32'd3);
      tick();
      checkOutput("drop_sat_5th", 32'(bus.drop_cnt_o), 32'd3);
      checkOutput("drop_sweep_done", 32'(bus.ready_o), 32'd1);
      applyStimulus(1'b0, 2'd0, '0, 1'b0);
      checkOutput("drop_set0_unchanged", 32'(bus.rdata_o), 32'(ONES));
      applyStimulus(1'b0, 2'd1, '0, 1'b0);
      checkOutput("drop_set1_unchanged", 32'(bus.rdata_o), 32'(ONES));

      // Clear at sweep cycle 2 restarts the sweep
      applyStimulus(1'b0, 2'd0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, 2'd0, '0, 1'b0);
      tick();
      checkOutput("restart_c1_ready", 32'(bus.ready_o), 32'd0);
      applyStimulus(1'b0, 2'd0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, 2'd0, '0, 1'b0);
      checkOutput("restart_clr_ready", 32'(bus.ready_o), 32'd0);
      for (int i = 1; i < 4; i++) begin
         tick();
         checkOutput($sformatf("restart_ready_c%0d", i), 32'(bus.ready_o), 32'd0);
      end
      tick();
      checkOutput("restart_ready_up", 32'(bus.ready_o), 32'd1);
      checkOutput("restart_drop_kept", 32'(bus.drop_cnt_o), 32'd3);

      // Synchronous reset in IDLE after writes; a write in the reset cycle is lost
      applyStimulus(1'b1, 2'd1, 6'b101010, 1'b0);
      tick();
      applyStimulus(1'b0, 2'd1, '0, 1'b0);
      checkOutput("pre_rst_wr1", 32'(bus.rdata_o), 32'(6'b101010));
      rstn = 1'b0;
      applyStimulus(1'b1, 2'd2, 6'b000000, 1'b0);
      tick();
      rstn = 1'b1;
      applyStimulus(1'b0, 2'd0, '0, 1'b0);
      checkOutput("rst2_ready", 32'(bus.ready_o), 32'd0);
      checkOutput("rst2_drop", 32'(bus.drop_cnt_o), 32'd0);
      for (int i = 1; i < 4; i++) begin
         tick();
         checkOutput($sformatf("rst2_ready_c%0d", i), 32'(bus.ready_o), 32'd0);
      end
      tick();
      checkOutput("rst2_ready_up", 32'(bus.ready_o), 32'd1);
      checkAllSets("rst2");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
